// File: rtl/ddr3_init_pkg.sv
// Shared types and constants for the DDR3 power-up / re-init sequencer.
package ddr3_init_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_CKE  = 4'd1,
    S_TXPR = 4'd2,
    S_MR2  = 4'd3,
    S_MR3  = 4'd4,
    S_MR1  = 4'd5,
    S_MR0  = 4'd6,
    S_ZQ   = 4'd7,
    S_DONE = 4'd8
  } init_state_t;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_MRS  = 3'b000;
  localparam logic [2:0] CMD_ZQCL = 3'b110;

  localparam int MR0_IDX = 0;
  localparam int MR1_IDX = 1;
  localparam int MR2_IDX = 2;
  localparam int MR3_IDX = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter reload value for an N-cycle dwell; N=0 still dwells one cycle.
  function automatic int dwell(input int n);
    return (n <= 1) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/ddr3_init_seq_if.sv
// DDR3 pin bundle driven by the init sequencer (master) toward the DRAM (slave).
// No handshake: every pin is valid in every cycle, the slave cannot stall the master.
interface ddr3_init_seq_if #(
  parameter int ADDR_BITS = 14,
  parameter int BA_BITS   = 3,
  parameter int CS_BITS   = 1
);
  logic                 ddr3_reset_n;
  logic [CS_BITS-1:0]   ddr3_cke;
  logic [CS_BITS-1:0]   ddr3_cs_n;
  logic                 ddr3_ras_n;
  logic                 ddr3_cas_n;
  logic                 ddr3_we_n;
  logic [BA_BITS-1:0]   ddr3_ba;
  logic [ADDR_BITS-1:0] ddr3_addr;
  logic [CS_BITS-1:0]   ddr3_odt;

  modport master (
    output ddr3_reset_n, ddr3_cke, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n,
           ddr3_we_n, ddr3_ba, ddr3_addr, ddr3_odt
  );

  modport slave (
    input  ddr3_reset_n, ddr3_cke, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n,
           ddr3_we_n, ddr3_ba, ddr3_addr, ddr3_odt
  );
endinterface

// File: rtl/ddr3_init_timer.sv
// Load-and-down-count dwell timer; expired while the count sits at zero.
module ddr3_init_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/ddr3_init_seq.sv
// DDR3 reset / MRS / ZQCL power-up sequencer with registered pin outputs.
// Build option DDR3_INIT_ZQCL_EN adds the ZQCL step before init_done.
module ddr3_init_seq
  import ddr3_init_pkg::*;
#(
  parameter int ADDR_BITS   = 14,
  parameter int BA_BITS     = 3,
  parameter int CS_BITS     = 1,
  parameter int RESET_CYC   = 40000,
  parameter int CKE_CYC     = 100000,
  parameter int TXPR_CYC    = 144,
  parameter int TMRD_CYC    = 4,
  parameter int TMOD_CYC    = 12,
  parameter int TZQINIT_CYC = 512,
  parameter logic [ADDR_BITS-1:0] MR0_VAL = ADDR_BITS'('h0520),
  parameter logic [ADDR_BITS-1:0] MR1_VAL = ADDR_BITS'('h0044),
  parameter logic [ADDR_BITS-1:0] MR2_VAL = ADDR_BITS'('h0008),
  parameter logic [ADDR_BITS-1:0] MR3_VAL = ADDR_BITS'('h0000)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reinit,
  ddr3_init_seq_if.master     ddr,
  output logic                init_busy,
  output logic                init_done,
  output logic [3:0]          init_state
);
  localparam int MAX_CYC = max_of(max_of(max_of(RESET_CYC, CKE_CYC), max_of(TXPR_CYC, TMRD_CYC)),
                                  max_of(max_of(TMOD_CYC, TZQINIT_CYC), 1));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  init_state_t          state, next_state;
  logic                 start;
  logic                 load, expired;
  logic [CNT_W-1:0]     load_val;

  logic                 reset_d, reset_q;
  logic [CS_BITS-1:0]   cke_d, cke_q, cs_d, cs_q;
  logic [2:0]           cmd_d, cmd_q;
  logic [BA_BITS-1:0]   ba_d, ba_q;
  logic [ADDR_BITS-1:0] addr_d, addr_q;
  logic                 busy_d, busy_q, done_d, done_q;

  ddr3_init_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_comb begin
    next_state = state;
    case (state)
      // start marks the first cycle after reset, when S_RST's dwell is loaded
      S_RST:  if (!start && expired) next_state = S_CKE;
      S_CKE:  if (expired) next_state = S_TXPR;
      S_TXPR: if (expired) next_state = S_MR2;
      S_MR2:  if (expired) next_state = S_MR3;
      S_MR3:  if (expired) next_state = S_MR1;
      S_MR1:  if (expired) next_state = S_MR0;
`ifdef DDR3_INIT_ZQCL_EN
      S_MR0:  if (expired) next_state = S_ZQ;
      S_ZQ:   if (expired) next_state = S_DONE;
`else
      S_MR0:  if (expired) next_state = S_DONE;
`endif
      S_DONE: if (reinit) next_state = S_RST;
      default: next_state = S_RST;
    endcase

    load     = start || (next_state != state);
    load_val = '0;
    case (next_state)
      S_RST:                  load_val = CNT_W'(dwell(RESET_CYC));
      S_CKE:                  load_val = CNT_W'(dwell(CKE_CYC));
      S_TXPR:                 load_val = CNT_W'(dwell(TXPR_CYC));
      S_MR2, S_MR3, S_MR1:    load_val = CNT_W'(dwell(TMRD_CYC));
      S_MR0:                  load_val = CNT_W'(dwell(TMOD_CYC));
      S_ZQ:                   load_val = CNT_W'(dwell(TZQINIT_CYC));
      default:                load_val = '0;
    endcase

    // Pin values for the cycle after this edge, so every output is a flop.
    reset_d = (next_state != S_RST);
    cke_d   = (next_state inside {S_RST, S_CKE}) ? '0 : '1;
    cs_d    = (next_state inside {S_RST, S_CKE}) ? '1 : '0;
    cmd_d   = CMD_NOP;
    ba_d    = '0;
    addr_d  = '0;
    if (next_state != state) begin
      case (next_state)
        S_MR2: begin cmd_d = CMD_MRS; ba_d = BA_BITS'(MR2_IDX); addr_d = MR2_VAL; end
        S_MR3: begin cmd_d = CMD_MRS; ba_d = BA_BITS'(MR3_IDX); addr_d = MR3_VAL; end
        S_MR1: begin cmd_d = CMD_MRS; ba_d = BA_BITS'(MR1_IDX); addr_d = MR1_VAL; end
        S_MR0: begin cmd_d = CMD_MRS; ba_d = BA_BITS'(MR0_IDX); addr_d = MR0_VAL; end
`ifdef DDR3_INIT_ZQCL_EN
        S_ZQ:  begin cmd_d = CMD_ZQCL; addr_d[10] = 1'b1; end
`endif
        default: cmd_d = CMD_NOP;
      endcase
    end
    busy_d = (next_state != S_DONE);
    done_d = (next_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RST;
      start   <= 1'b1;
      reset_q <= 1'b0;
      cke_q   <= '0;
      cs_q    <= '1;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      start   <= 1'b0;
      reset_q <= reset_d;
      cke_q   <= cke_d;
      cs_q    <= cs_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ddr.ddr3_reset_n = reset_q;
  assign ddr.ddr3_cke     = cke_q;
  assign ddr.ddr3_cs_n    = cs_q;
  assign ddr.ddr3_ras_n   = cmd_q[2];
  assign ddr.ddr3_cas_n   = cmd_q[1];
  assign ddr.ddr3_we_n    = cmd_q[0];
  assign ddr.ddr3_ba      = ba_q;
  assign ddr.ddr3_addr    = addr_q;
  assign ddr.ddr3_odt     = '0;
  assign init_busy        = busy_q;
  assign init_done        = done_q;
  assign init_state       = state;
endmodule

// File: tb/tb_ddr3_init_seq.sv
// Scoreboard bench for ddr3_init_seq: pin events are queued by the driver, popped by a monitor.
module tb_ddr3_init_seq;
  localparam int EW = 40;
  localparam int EV_RSTN_FALL = 1, EV_CKE_FALL = 2, EV_RSTN_RISE = 3, EV_CKE_RISE = 4;
  localparam int EV_CMD = 5, EV_DONE_FALL = 6, EV_DONE_RISE = 7;
  localparam logic [13:0] MR0_V = 14'h0520;
  localparam logic [13:0] MR1_V = 14'h0044;
  localparam logic [13:0] MR2_V = 14'h0218;
  localparam logic [13:0] MR3_V = 14'h0003;
`ifdef DDR3_INIT_ZQCL_EN
  localparam int T_DONE = 75, N_CMDS = 5, LEFT_AT_41 = 4;
`else
  localparam int T_DONE = 59, N_CMDS = 4, LEFT_AT_41 = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reinit = 1'b0;
  logic       init_busy, init_done;
  logic [3:0] init_state;

  ddr3_init_seq_if #(.ADDR_BITS(14), .BA_BITS(3), .CS_BITS(1)) ddr ();

  ddr3_init_seq #(
    .ADDR_BITS(14), .BA_BITS(3), .CS_BITS(1),
    .RESET_CYC(10), .CKE_CYC(20), .TXPR_CYC(5), .TMRD_CYC(4), .TMOD_CYC(12), .TZQINIT_CYC(16),
    .MR0_VAL(MR0_V), .MR1_VAL(MR1_V), .MR2_VAL(MR2_V), .MR3_VAL(MR3_V)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reinit     (reinit),
    .ddr        (ddr),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .init_state (init_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- scoreboard state ----------------
  int  base = 0;
  bit  mon_en = 1'b0;
  int  cmd_cnt = 0;
  int  total = 0;
  int  bad = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_ev(input int kind, input int cyc, input logic [2:0] cmd,
                                          input logic [2:0] ba, input logic [13:0] addr);
    return {kind[3:0], cyc[15:0], cmd, ba, addr};
  endfunction

  task automatic push(input int kind, input int cyc, input logic [2:0] cmd,
                      input logic [2:0] ba, input logic [13:0] addr);
    exp_q.push_back(mk_ev(kind, cyc, cmd, ba, addr));
  endtask

  // Full sequence relative to cycle 0, hand-derived for the bench timing parameters.
  task automatic push_seq();
    push(EV_RSTN_RISE, 10, 3'b000, 3'd0, 14'h0);
    push(EV_CKE_RISE,  30, 3'b000, 3'd0, 14'h0);
    push(EV_CMD,       35, 3'b000, 3'd2, MR2_V);
    push(EV_CMD,       39, 3'b000, 3'd3, MR3_V);
    push(EV_CMD,       43, 3'b000, 3'd1, MR1_V);
    push(EV_CMD,       47, 3'b000, 3'd0, MR0_V);
`ifdef DDR3_INIT_ZQCL_EN
    push(EV_CMD,       59, 3'b110, 3'd0, 14'h0400);
`endif
    push(EV_DONE_RISE, T_DONE, 3'b000, 3'd0, 14'h0);
  endtask

  task automatic emit(input logic [EW-1:0] act);
    logic [EW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got=%h exp=none", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL event got=%h exp=%h", act, e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic p_rstn, p_cke, p_done, is_cmd;
    logic [2:0] cmd;
    int c;
    p_rstn = 1'b0; p_cke = 1'b0; p_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        c = edge_cnt - base - 1;
        cmd = {ddr.ddr3_ras_n, ddr.ddr3_cas_n, ddr.ddr3_we_n};
        if (p_rstn && !ddr.ddr3_reset_n)   emit(mk_ev(EV_RSTN_FALL, c, 3'b000, 3'd0, 14'h0));
        if (p_cke && !ddr.ddr3_cke[0])     emit(mk_ev(EV_CKE_FALL,  c, 3'b000, 3'd0, 14'h0));
        if (!p_rstn && ddr.ddr3_reset_n)   emit(mk_ev(EV_RSTN_RISE, c, 3'b000, 3'd0, 14'h0));
        if (!p_cke && ddr.ddr3_cke[0])     emit(mk_ev(EV_CKE_RISE,  c, 3'b000, 3'd0, 14'h0));
        is_cmd = !ddr.ddr3_cs_n[0] && (cmd != 3'b111);
        if (is_cmd) begin
          emit(mk_ev(EV_CMD, c, cmd, ddr.ddr3_ba, ddr.ddr3_addr));
          cmd_cnt++;
        end else begin
          check("idle_ba_addr", 64'({ddr.ddr3_ba, ddr.ddr3_addr}), 64'(0));
        end
        if (p_done && !init_done)          emit(mk_ev(EV_DONE_FALL, c, 3'b000, 3'd0, 14'h0));
        if (!p_done && init_done)          emit(mk_ev(EV_DONE_RISE, c, 3'b000, 3'd0, 14'h0));
        check("odt_low", 64'(ddr.ddr3_odt), 64'(0));
        check("cs_vs_cke", 64'(ddr.ddr3_cs_n ^ ddr.ddr3_cke), 64'(1));
        check("busy_vs_done", 64'(init_busy ^ init_done), 64'(1));
      end
      p_rstn = ddr.ddr3_reset_n;
      p_cke  = ddr.ddr3_cke[0];
      p_done = init_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int k);
    int n;
    n = 0;
    while ((edge_cnt - base - 1) != k && n < 500) begin
      at_neg();
      n++;
    end
    check("wait_cycle_reached", 64'(edge_cnt - base - 1), 64'(k));
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      at_neg();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    repeat (10) at_neg();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_reset_n"}, 64'(ddr.ddr3_reset_n), 64'(0));
    check({tag, "_cke"},     64'(ddr.ddr3_cke),     64'(0));
    check({tag, "_cs_n"},    64'(ddr.ddr3_cs_n),    64'(1));
    check({tag, "_ras_n"},   64'(ddr.ddr3_ras_n),   64'(1));
    check({tag, "_cas_n"},   64'(ddr.ddr3_cas_n),   64'(1));
    check({tag, "_we_n"},    64'(ddr.ddr3_we_n),    64'(1));
    check({tag, "_ba"},      64'(ddr.ddr3_ba),      64'(0));
    check({tag, "_addr"},    64'(ddr.ddr3_addr),    64'(0));
    check({tag, "_odt"},     64'(ddr.ddr3_odt),     64'(0));
    check({tag, "_busy"},    64'(init_busy),        64'(1));
    check({tag, "_done"},    64'(init_done),        64'(0));
    check({tag, "_state"},   64'(init_state),       64'(0));
  endtask

  task automatic check_done_vals(input string tag);
    check({tag, "_state"},   64'(init_state),       64'(8));
    check({tag, "_busy"},    64'(init_busy),        64'(0));
    check({tag, "_done"},    64'(init_done),        64'(1));
    check({tag, "_cke"},     64'(ddr.ddr3_cke),     64'(1));
    check({tag, "_reset_n"}, 64'(ddr.ddr3_reset_n), 64'(1));
  endtask

  task automatic pulse_reinit_from_done();
    cmd_cnt = 0;
    push(EV_RSTN_FALL, 0, 3'b000, 3'd0, 14'h0);
    push(EV_CKE_FALL,  0, 3'b000, 3'd0, 14'h0);
    push(EV_DONE_FALL, 0, 3'b000, 3'd0, 14'h0);
    push_seq();
    reinit = 1'b1;
    base = edge_cnt;
    at_neg();
    reinit = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) at_neg();
    check_reset_vals("por");

    // nominal sequence from reset release
    mon_en = 1'b1;
    cmd_cnt = 0;
    push_seq();
    rst_n = 1'b1;
    base = edge_cnt;
    drain("nominal_drain", 200);
    check("nominal_cmd_count", 64'(cmd_cnt), 64'(N_CMDS));
    check_done_vals("nominal_done");

    // reinit from S_DONE, plus an ignored reinit at cycle 40 of the replay
    pulse_reinit_from_done();
    wait_cycle(39);
    reinit = 1'b1;
    at_neg();
    reinit = 1'b0;
    drain("reinit_drain", 200);
    check("reinit_cmd_count", 64'(cmd_cnt), 64'(N_CMDS));
    check_done_vals("reinit_done");

    // async reset at cycle 41 of a replay, then full restart
    pulse_reinit_from_done();
    wait_cycle(41);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    mon_en = 1'b0;
    check("mid_reset_pending", 64'(exp_q.size()), 64'(LEFT_AT_41));
    exp_q.delete();
    repeat (5) at_neg();
    check_reset_vals("mid_hold");
    mon_en = 1'b1;
    cmd_cnt = 0;
    push_seq();
    rst_n = 1'b1;
    base = edge_cnt;
    drain("restart_drain", 200);
    check("restart_cmd_count", 64'(cmd_cnt), 64'(N_CMDS));
    check_done_vals("restart_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
